// File: rtl/attn_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module      : attn_stream_bridge
// Description : Stream front end for self_attention_top. Collects one frame of
//               words (x, WQ, WK, WV, WO) from a valid/ready input stream into
//               registered arrays. It then pulses core_start, waits for
//               core_done, captures core_out, and replays the result on a
//               valid/ready output stream.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_last   input word stream
//   x_out, WQ_out..WO_out     registered operand arrays to the core
//   core_start / core_done    core handshake (start pulse, done pulse)
//   core_out                  core result, sampled while core_done is high
//   m_valid/m_ready/m_data/m_last   output word stream
//   frame_err                 one-cycle pulse on a framing error
//   busy                      high whenever a frame is not being loaded
// ============================================================================
module attn_stream_bridge #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int E          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] x_out  [L*E],
  output logic [DATA_WIDTH-1:0] WQ_out [E*E],
  output logic [DATA_WIDTH-1:0] WK_out [E*E],
  output logic [DATA_WIDTH-1:0] WV_out [E*E],
  output logic [DATA_WIDTH-1:0] WO_out [E*E],
  output logic                  core_start,
  input  logic                  core_done,
  input  logic [DATA_WIDTH-1:0] core_out [L*E],
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int NX    = L * E;
  localparam int NW    = E * E;
  localparam int TOTAL = NX + 4 * NW;
  localparam int CW    = $clog2(TOTAL);
  localparam int XW    = (NX > 1) ? $clog2(NX) : 1;
  localparam int WW    = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_SEND  = 2'd3;

  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [XW-1:0]         r_oidx;
  logic                  r_frame_err;
  logic                  r_up;     // low only until the first edge after reset
  logic [DATA_WIDTH-1:0] r_res [NX];

  logic                  w_s_hs;
  logic                  w_m_hs;
  logic                  w_cnt_last;
  logic                  w_o_last;
  logic [2:0]            w_sel;
  logic [CW-1:0]         w_base;
  logic [XW-1:0]         w_xi;
  logic [WW-1:0]         w_wi;

  // All stream-facing outputs decode from registered state only.
  assign s_ready    = r_up && (r_state == S_LOAD);
  assign core_start = (r_state == S_START);
  assign busy       = (r_state != S_LOAD);
  assign m_valid    = (r_state == S_SEND);
  assign m_last     = m_valid && w_o_last;
  assign m_data     = m_valid ? r_res[r_oidx] : '0;
  assign frame_err  = r_frame_err;

  assign w_s_hs     = s_valid && s_ready;
  assign w_m_hs     = m_valid && m_ready;
  assign w_cnt_last = (r_cnt == CW'(TOTAL - 1));
  assign w_o_last   = (r_oidx == XW'(NX - 1));

  // Split the global word index into target array and offset within it.
  always_comb begin
    w_sel  = 3'd0;
    w_base = '0;
    if (r_cnt >= CW'(NX + 3 * NW)) begin
      w_sel  = 3'd4;
      w_base = CW'(NX + 3 * NW);
    end else if (r_cnt >= CW'(NX + 2 * NW)) begin
      w_sel  = 3'd3;
      w_base = CW'(NX + 2 * NW);
    end else if (r_cnt >= CW'(NX + NW)) begin
      w_sel  = 3'd2;
      w_base = CW'(NX + NW);
    end else if (r_cnt >= CW'(NX)) begin
      w_sel  = 3'd1;
      w_base = CW'(NX);
    end
    w_xi = XW'(r_cnt);
    w_wi = WW'(r_cnt - w_base);
  end

  // Operand arrays: written only by accepted input words, so they hold
  // steady for the whole start/wait/send phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NX; i++) x_out[i] <= '0;
      for (int i = 0; i < NW; i++) begin
        WQ_out[i] <= '0;
        WK_out[i] <= '0;
        WV_out[i] <= '0;
        WO_out[i] <= '0;
      end
    end else if (w_s_hs) begin
      case (w_sel)
        3'd0:    x_out[w_xi]  <= s_data;
        3'd1:    WQ_out[w_wi] <= s_data;
        3'd2:    WK_out[w_wi] <= s_data;
        3'd3:    WV_out[w_wi] <= s_data;
        default: WO_out[w_wi] <= s_data;
      endcase
    end
  end

  // Result buffer: snapshot of core_out taken on the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NX; i++) r_res[i] <= '0;
    end else if ((r_state == S_WAIT) && core_done) begin
      r_res <= core_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_oidx      <= '0;
      r_frame_err <= 1'b0;
      r_up        <= 1'b0;
    end else begin
      r_up        <= 1'b1;
      r_frame_err <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_s_hs) begin
            if (w_cnt_last && s_last) begin
              r_state <= S_START;
              r_cnt   <= '0;
            end else if (w_cnt_last || s_last) begin
              // Early or missing last marker: drop the frame and restart.
              r_frame_err <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            r_state <= S_SEND;
            r_oidx  <= '0;
          end
        end
        S_SEND: begin
          if (w_m_hs) begin
            if (w_o_last) begin
              r_state <= S_LOAD;
              r_oidx  <= '0;
            end else begin
              r_oidx <= r_oidx + XW'(1);
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire
